// File: rtl/mips_boot_pkg.sv
// Shared definitions for the instruction-memory boot loader: state codes,
// default frame marker and header size.
package mips_boot_pkg;

    typedef enum logic [2:0] {
        SYNC   = 3'd0,
        LEN_HI = 3'd1,
        LEN_LO = 3'd2,
        DATA   = 3'd3,
        CSUM   = 3'd4,
        RUN    = 3'd5,
        ERR    = 3'd6
    } boot_state_t;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
    localparam int         HDR_LEN       = 3;

endpackage

// File: rtl/byte_packer.sv
// Big-endian 4-byte assembler: the first byte of a word lands in [31:24].
// word_out/word_valid are combinational so the 4th byte is usable on its own edge.
module byte_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  byte_in,
    input  logic        byte_en,
    input  logic        clear,
    output logic [31:0] word_out,
    output logic        word_valid
);

    logic [1:0]  r_cnt;
    logic [23:0] r_sh;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= 2'd0;
            r_sh  <= 24'd0;
        end else if (clear) begin
            r_cnt <= 2'd0;
            r_sh  <= 24'd0;
        end else if (byte_en) begin
            r_cnt <= r_cnt + 2'd1;
            r_sh  <= {r_sh[15:0], byte_in};
        end
    end

    assign word_out   = {r_sh, byte_in};
    assign word_valid = byte_en && !clear && (r_cnt == 2'd3);

endmodule

// File: rtl/im_boot_loader.sv
// Framed byte-stream loader for instruction memory; holds the core in reset
// until a checksum-verified image has been written.
module im_boot_loader
    import mips_boot_pkg::*;
#(
    parameter int         ADDR_W    = 10,
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    output logic              cpu_rst,
    output logic              load_done,
    output logic              load_err,
    output logic [ADDR_W:0]   words_loaded
);

    localparam logic [16:0]   CAP   = 17'(1) << ADDR_W;
    localparam logic [ADDR_W:0] ONE = (ADDR_W+1)'(1);

    boot_state_t      r_state;
    logic [7:0]       r_len_hi;
    logic [ADDR_W:0]  r_len;
    logic [7:0]       r_xor;

    logic             w_acc;
    logic [16:0]      w_len_new;
    logic             w_last;
    logic [31:0]      w_word;
    logic             w_word_valid;

    assign w_acc     = in_valid && in_ready;
    assign w_len_new = {1'b0, r_len_hi, in_data};
    // words_loaded has already counted every earlier word: the next word needs 4 more bytes
    assign w_last    = ((words_loaded + ONE) == r_len);

    byte_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .byte_in    (in_data),
        .byte_en    (w_acc && (r_state == DATA)),
        .clear      (r_state != DATA),
        .word_out   (w_word),
        .word_valid (w_word_valid)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= SYNC;
            r_len_hi     <= 8'd0;
            r_len        <= '0;
            r_xor        <= 8'd0;
            in_ready     <= 1'b0;
            im_we        <= 1'b0;
            im_addr      <= '0;
            im_wdata     <= 32'd0;
            cpu_rst      <= 1'b1;
            load_done    <= 1'b0;
            load_err     <= 1'b0;
            words_loaded <= '0;
        end else begin
            im_we <= 1'b0;
            if (im_we) begin
                im_addr      <= im_addr + ADDR_W'(1);
                words_loaded <= words_loaded + ONE;
            end
            if (r_state != RUN && r_state != ERR)
                in_ready <= 1'b1;

            case (r_state)
                SYNC: if (w_acc && in_data == SYNC_BYTE) r_state <= LEN_HI;
                LEN_HI: if (w_acc) begin
                    r_len_hi <= in_data;
                    r_state  <= LEN_LO;
                end
                LEN_LO: if (w_acc) begin
                    r_len <= w_len_new[ADDR_W:0];
                    if (w_len_new > CAP) begin
                        r_state  <= ERR;
                        in_ready <= 1'b0;
                        load_err <= 1'b1;
                    end else if (w_len_new == 17'd0) begin
                        r_state <= CSUM;
                    end else begin
                        r_state <= DATA;
                    end
                end
                DATA: if (w_acc) begin
                    r_xor <= r_xor ^ in_data;
                    if (w_word_valid) begin
                        im_wdata <= w_word;
                        im_we    <= 1'b1;
                        if (w_last) r_state <= CSUM;
                    end
                end
                CSUM: if (w_acc) begin
                    in_ready <= 1'b0;
                    if (in_data == r_xor) begin
                        r_state   <= RUN;
                        cpu_rst   <= 1'b0;
                        load_done <= 1'b1;
                    end else begin
                        r_state  <= ERR;
                        load_err <= 1'b1;
                    end
                end
                RUN, ERR: in_ready <= 1'b0;
                default: begin
                    r_state  <= ERR;
                    in_ready <= 1'b0;
                    load_err <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_im_boot_loader.sv
// Self-checking bench for im_boot_loader: directed frames plus randomized
// frames checked against a frame-parsing reference model.
module tb_im_boot_loader;

    typedef logic [7:0]  bq_t[$];
    typedef logic [31:0] wq_t[$];

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'd0;

    logic        in_ready, im_we, cpu_rst, load_done, load_err;
    logic [9:0]  im_addr;
    logic [31:0] im_wdata;
    logic [10:0] words_loaded;

    logic        in_ready4, im_we4, cpu_rst4, load_done4, load_err4;
    logic [3:0]  im_addr4;
    logic [31:0] im_wdata4;
    logic [4:0]  words4;

    int n_pass = 0;
    int n_tot  = 0;

    int          q_addr[$];
    logic [31:0] q_data[$];
    int          n4 = 0;
    int          last4 = -1;

    wq_t m_words;
    bit  m_done, m_err;

    im_boot_loader #(.ADDR_W(10)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
        .cpu_rst(cpu_rst), .load_done(load_done), .load_err(load_err),
        .words_loaded(words_loaded)
    );

    im_boot_loader #(.ADDR_W(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready4), .im_we(im_we4), .im_addr(im_addr4), .im_wdata(im_wdata4),
        .cpu_rst(cpu_rst4), .load_done(load_done4), .load_err(load_err4),
        .words_loaded(words4)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (im_we) begin
            q_addr.push_back(int'(im_addr));
            q_data.push_back(im_wdata);
        end
        if (im_we4) begin
            n4++;
            last4 = int'(im_addr4);
        end
    end

    // Reference: parse the frame by its rules and decide the writes and outcome.
    task automatic model_frame(input bq_t s, input int cap);
        int i = 0;
        int n;
        logic [7:0] x = 8'd0;
        m_words.delete();
        m_done = 0;
        m_err  = 0;
        while (i < s.size() && s[i] != 8'hA5) i++;
        if (i + 2 >= s.size()) return;
        n = int'({s[i+1], s[i+2]});
        i += 3;
        if (n > cap) begin
            m_err = 1;
            return;
        end
        for (int w = 0; w < n; w++) begin
            m_words.push_back({s[i], s[i+1], s[i+2], s[i+3]});
            x = x ^ s[i] ^ s[i+1] ^ s[i+2] ^ s[i+3];
            i += 4;
        end
        if (s[i] == x) m_done = 1;
        else m_err = 1;
    endtask

    task automatic build_frame(input bq_t pre, input wq_t w, input bit bad, output bq_t f);
        logic [7:0] x = 8'd0;
        logic [31:0] v;
        f = pre;
        f.push_back(8'hA5);
        f.push_back(8'(w.size() >> 8));
        f.push_back(8'(w.size()));
        foreach (w[k]) begin
            v = w[k];
            for (int b = 3; b >= 0; b--) begin
                f.push_back(v[b*8 +: 8]);
                x = x ^ v[b*8 +: 8];
            end
        end
        f.push_back(bad ? (x ^ 8'(1 + $urandom_range(0, 254))) : x);
    endtask

    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            n_tot++;
            $display("FAIL send_timeout: in_ready=%0b after %0d cycles, required 1", in_ready, t);
        end
        @(negedge clk);
    endtask

    task automatic send_stream(input bq_t s, input bit gaps);
        foreach (s[k]) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge clk);
            end
            send_byte(s[k]);
        end
        in_valid = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        q_addr.delete();
        q_data.delete();
        n4 = 0;
        last4 = -1;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #2 rst = 1'b1;
        #1;
        n_tot++; if ({in_ready, im_we, cpu_rst, load_done, load_err} !== 5'b00100)
            $display("FAIL reset_flags: got %b required 00100", {in_ready, im_we, cpu_rst, load_done, load_err});
        else n_pass++;
        n_tot++; if (im_addr !== 10'd0 || im_wdata !== 32'd0 || words_loaded !== 11'd0)
            $display("FAIL reset_regs: addr=%0d wdata=%h words=%0d required 0", im_addr, im_wdata, words_loaded);
        else n_pass++;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_tot++; if (in_ready !== 1'b1 || cpu_rst !== 1'b1)
            $display("FAIL reset_release: in_ready=%b cpu_rst=%b required 1 1", in_ready, cpu_rst);
        else n_pass++;
    endtask

    task automatic test_basic(input string nm, input bq_t pre, input bit bad);
        bq_t f;
        wq_t w;
        w.push_back(32'h20080005);
        w.push_back(32'h8C090000);
        apply_reset();
        build_frame(pre, w, bad, f);
        send_stream(f, 1'b0);
        n_tot++; if (cpu_rst !== bad || load_done !== !bad || load_err !== bad || im_we !== 1'b0)
            $display("FAIL %s_csum_edge: cpu_rst=%b done=%b err=%b we=%b, required %b %b %b 0",
                     nm, cpu_rst, load_done, load_err, im_we, bad, !bad, bad);
        else n_pass++;
        @(negedge clk);
        n_tot++; if (q_data.size() != 2)
            $display("FAIL %s_count: got %0d writes required 2", nm, q_data.size());
        else n_pass++;
        foreach (w[k]) if (k < q_data.size()) begin
            n_tot++; if (q_addr[k] != k || q_data[k] !== w[k])
                $display("FAIL %s_word%0d: got %0d:%h required %0d:%h", nm, k, q_addr[k], q_data[k], k, w[k]);
            else n_pass++;
        end
        n_tot++; if (in_ready !== 1'b0 || words_loaded !== 11'd2)
            $display("FAIL %s_after: in_ready=%b words=%0d required 0 2", nm, in_ready, words_loaded);
        else n_pass++;
    endtask

    task automatic test_oversize();
        bq_t f = '{8'hA5, 8'h00, 8'h11};
        apply_reset();
        send_stream(f, 1'b0);
        @(negedge clk);
        n_tot++; if (load_err4 !== 1'b1 || cpu_rst4 !== 1'b1 || in_ready4 !== 1'b0 || n4 != 0)
            $display("FAIL oversize: err=%b cpu_rst=%b in_ready=%b writes=%0d required 1 1 0 0",
                     load_err4, cpu_rst4, in_ready4, n4);
        else n_pass++;
        n_tot++; if (load_err !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL oversize_wide: err=%b in_ready=%b required 0 1", load_err, in_ready);
        else n_pass++;
    endtask

    task automatic test_full_capacity();
        bq_t f, pre;
        wq_t w;
        for (int k = 0; k < 16; k++) w.push_back($urandom);
        apply_reset();
        build_frame(pre, w, 1'b0, f);
        model_frame(f, 16);
        send_stream(f, 1'b0);
        @(negedge clk);
        n_tot++; if (n4 != 16 || last4 != 15 || words4 !== 5'd16 || im_addr4 !== 4'd0)
            $display("FAIL full_cap: writes=%0d last=%0d words=%0d addr=%0d required 16 15 16 0",
                     n4, last4, words4, im_addr4);
        else n_pass++;
        n_tot++; if (load_done4 !== m_done || load_err4 !== m_err || cpu_rst4 !== !m_done)
            $display("FAIL full_cap_status: done=%b err=%b cpu_rst=%b required %b %b %b",
                     load_done4, load_err4, cpu_rst4, m_done, m_err, !m_done);
        else n_pass++;
        n_tot++; if (q_data.size() != 16 || q_data[15] !== m_words[15])
            $display("FAIL full_cap_last: got %0d writes last=%h required 16 %h",
                     q_data.size(), (q_data.size() > 15) ? q_data[15] : 32'd0, m_words[15]);
        else n_pass++;
    endtask

    task automatic test_zero_len();
        bq_t f0 = '{8'hA5, 8'h00, 8'h00, 8'h00};
        bq_t f1 = '{8'hA5, 8'h00, 8'h00, 8'h01};
        apply_reset();
        send_stream(f0, 1'b0);
        n_tot++; if (load_done !== 1'b1 || cpu_rst !== 1'b0 || words_loaded !== 11'd0 || q_data.size() != 0)
            $display("FAIL zero_ok: done=%b cpu_rst=%b words=%0d writes=%0d required 1 0 0 0",
                     load_done, cpu_rst, words_loaded, q_data.size());
        else n_pass++;
        apply_reset();
        send_stream(f1, 1'b0);
        n_tot++; if (load_err !== 1'b1 || cpu_rst !== 1'b1 || load_done !== 1'b0)
            $display("FAIL zero_bad: err=%b cpu_rst=%b done=%b required 1 1 0", load_err, cpu_rst, load_done);
        else n_pass++;
    endtask

    task automatic test_midframe_reset();
        bq_t part = '{8'hA5, 8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        bq_t f, pre;
        wq_t w;
        apply_reset();
        send_stream(part, 1'b0);
        @(negedge clk);
        n_tot++; if (q_data.size() != 1 || q_data[0] !== 32'h11223344)
            $display("FAIL mid_partial: writes=%0d required 1 of 11223344", q_data.size());
        else n_pass++;
        rst = 1'b1;
        #1;
        n_tot++; if (cpu_rst !== 1'b1 || im_addr !== 10'd0 || words_loaded !== 11'd0 || in_ready !== 1'b0)
            $display("FAIL mid_reset: cpu_rst=%b addr=%0d words=%0d in_ready=%b required 1 0 0 0",
                     cpu_rst, im_addr, words_loaded, in_ready);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        q_addr.delete();
        q_data.delete();
        @(negedge clk);
        w.push_back(32'hDEADBEEF);
        w.push_back(32'h01234567);
        w.push_back(32'hCAFEF00D);
        build_frame(pre, w, 1'b0, f);
        send_stream(f, 1'b1);
        @(negedge clk);
        n_tot++; if (q_data.size() != 3 || q_addr[0] != 0 || q_data[0] !== w[0] || q_data[2] !== w[2])
            $display("FAIL mid_reload: writes=%0d first_addr=%0d required 3 writes from addr 0",
                     q_data.size(), (q_addr.size() > 0) ? q_addr[0] : -1);
        else n_pass++;
        n_tot++; if (load_done !== 1'b1 || cpu_rst !== 1'b0)
            $display("FAIL mid_done: done=%b cpu_rst=%b required 1 0", load_done, cpu_rst);
        else n_pass++;
    endtask

    task automatic test_random();
        bq_t f, pre;
        wq_t w;
        bit bad;
        for (int it = 0; it < 12; it++) begin
            pre.delete();
            w.delete();
            repeat ($urandom_range(0, 3)) pre.push_back(8'($urandom_range(0, 164)));
            repeat ($urandom_range(0, 12)) w.push_back($urandom);
            bad = ($urandom_range(0, 3) == 0);
            apply_reset();
            build_frame(pre, w, bad, f);
            model_frame(f, 1024);
            send_stream(f, 1'b1);
            @(negedge clk);
            n_tot++; if (q_data.size() != m_words.size() || words_loaded !== 11'(m_words.size()))
                $display("FAIL rand%0d_count: writes=%0d words=%0d required %0d",
                         it, q_data.size(), words_loaded, m_words.size());
            else n_pass++;
            foreach (m_words[k]) if (k < q_data.size()) begin
                n_tot++; if (q_addr[k] != k || q_data[k] !== m_words[k])
                    $display("FAIL rand%0d_word%0d: got %0d:%h required %0d:%h",
                             it, k, q_addr[k], q_data[k], k, m_words[k]);
                else n_pass++;
            end
            n_tot++; if (load_done !== m_done || load_err !== m_err || cpu_rst !== !m_done || in_ready !== 1'b0)
                $display("FAIL rand%0d_status: done=%b err=%b cpu_rst=%b in_ready=%b required %b %b %b 0",
                         it, load_done, load_err, cpu_rst, in_ready, m_done, m_err, !m_done);
            else n_pass++;
        end
    endtask

    initial begin
        bq_t none;
        bq_t junk = '{8'h00, 8'hFF, 8'h5A};
        test_reset();
        test_basic("basic", none, 1'b0);
        test_basic("garbage", junk, 1'b0);
        test_basic("badcsum", none, 1'b1);
        test_oversize();
        test_full_capacity();
        test_zero_len();
        test_midframe_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule
